// File: rtl/sopc_cap_mem_pkg.sv
// Shared types and constants for the anemometer capture on-chip RAM.
// Read latency is RD_LAT_BASE, or RD_LAT_OUTREG when the output register is built in.
package sopc_cap_mem_pkg;

   typedef enum logic [1:0] {
      RST   = 2'd0,
      CLEAR = 2'd1,
      READY = 2'd2
   } ram_state_t;

   localparam int RD_LAT_BASE   = 1;
   localparam int RD_LAT_OUTREG = 2;

   // Number of byte lanes in a data word.
   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sopc_cap_ram_core.sv
// True dual-port byte-enabled storage array with a registered read on each port.
// Reads return the pre-write contents; on a same-address double write port A owns its lanes.
module sopc_cap_ram_core
   import sopc_cap_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 5000,
   parameter int AW     = 13
) (
   input  logic                      clk,
   input  logic                      en,
   input  logic                      we_a,
   input  logic [AW-1:0]             addr_a,
   input  logic [be_w(DATA_W)-1:0]   be_a,
   input  logic [DATA_W-1:0]         wdata_a,
   output logic [DATA_W-1:0]         rdata_a,
   input  logic                      we_b,
   input  logic [AW-1:0]             addr_b,
   input  logic [be_w(DATA_W)-1:0]   be_b,
   input  logic [DATA_W-1:0]         wdata_b,
   output logic [DATA_W-1:0]         rdata_b
);

   localparam int BE_W = be_w(DATA_W);

   logic [BE_W-1:0][7:0] mem_q [DEPTH];

   // Port A is written last so it overrides port B on lanes both enable.
   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++) begin
         if (we_b && be_b[b]) begin
            mem_q[addr_b][b] <= wdata_b[8*b +: 8];
         end
         if (we_a && be_a[b]) begin
            mem_q[addr_a][b] <= wdata_a[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         rdata_a <= mem_q[addr_a];
         rdata_b <= mem_q[addr_b];
      end
   end

endmodule

// File: rtl/sopc_cap_onchip_ram_dp.sv
// Dual-port Avalon-MM RAM with post-reset zero sweep, read-valid pipeline and range checking.
// Define SOPC_CAP_RAM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module sopc_cap_onchip_ram_dp
   import sopc_cap_mem_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 13,
   parameter int DEPTH     = 5000,
   parameter int INIT_ZERO = 1
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clken,
   input  logic [ADDR_W-1:0]         s1_address,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [be_w(DATA_W)-1:0]   s1_byteenable,
   input  logic [DATA_W-1:0]         s1_writedata,
   output logic [DATA_W-1:0]         s1_readdata,
   output logic                      s1_readdatavalid,
   output logic                      s1_waitrequest,
   input  logic [ADDR_W-1:0]         s2_address,
   input  logic                      s2_chipselect,
   input  logic                      s2_read,
   input  logic                      s2_write,
   input  logic [be_w(DATA_W)-1:0]   s2_byteenable,
   input  logic [DATA_W-1:0]         s2_writedata,
   output logic [DATA_W-1:0]         s2_readdata,
   output logic                      s2_readdatavalid,
   output logic                      s2_waitrequest,
   output logic                      oor_err,
   output logic                      ready
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

   ram_state_t      state_q;
   logic [AW-1:0]   clr_cnt_q;
   logic            oor_q, oor_d;
   logic            rd1_vld_q, rd1_vld_d, rd1_oor_q, rd1_oor_d;
   logic            rd2_vld_q, rd2_vld_d, rd2_oor_q, rd2_oor_d;

   logic            stall;
   logic            acc1, acc2, wr1, wr2, rd1, rd2, oor1, oor2;
   logic            clr_we;

   logic                      we_a, we_b;
   logic [AW-1:0]             addr_a;
   logic [be_w(DATA_W)-1:0]   be_a;
   logic [DATA_W-1:0]         wdata_a;
   logic [DATA_W-1:0]         core_q1, core_q2;
   logic [DATA_W-1:0]         rd1_dat, rd2_dat;

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= RST;
         clr_cnt_q <= '0;
      end else if (clken) begin
         case (state_q)
            RST: begin
               state_q <= (INIT_ZERO != 0) ? CLEAR : READY;
            end
            CLEAR: begin
               if (clr_cnt_q == LAST_IDX) begin
                  state_q   <= READY;
                  clr_cnt_q <= '0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + AW'(1);
               end
            end
            default: begin
               state_q <= READY;
            end
         endcase
      end
   end

   assign stall          = (state_q != READY);
   assign s1_waitrequest = stall;
   assign s2_waitrequest = stall;
   assign ready          = (state_q == READY);

   // --------------------------------------------------------- access decode
   assign acc1 = s1_chipselect & (s1_read | s1_write) & ~stall & clken;
   assign acc2 = s2_chipselect & (s2_read | s2_write) & ~stall & clken;
   assign wr1  = acc1 & s1_write;
   assign wr2  = acc2 & s2_write;
   assign rd1  = acc1 & ~s1_write;
   assign rd2  = acc2 & ~s2_write;
   assign oor1 = ({1'b0, s1_address} >= DEPTH_C);
   assign oor2 = ({1'b0, s2_address} >= DEPTH_C);

   // The clear sweep borrows port A; the masters are stalled while it runs.
   assign clr_we  = (state_q == CLEAR) & clken;
   assign we_a    = reset_n & (clr_we | (wr1 & ~oor1));
   assign addr_a  = clr_we ? clr_cnt_q : s1_address[AW-1:0];
   assign be_a    = clr_we ? '1 : s1_byteenable;
   assign wdata_a = clr_we ? '0 : s1_writedata;
   assign we_b    = reset_n & wr2 & ~oor2;

   sopc_cap_ram_core #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_core (
      .clk     (clk),
      .en      (clken),
      .we_a    (we_a),
      .addr_a  (addr_a),
      .be_a    (be_a),
      .wdata_a (wdata_a),
      .rdata_a (core_q1),
      .we_b    (we_b),
      .addr_b  (s2_address[AW-1:0]),
      .be_b    (s2_byteenable),
      .wdata_b (s2_writedata),
      .rdata_b (core_q2)
   );

   // ------------------------------------------------------ read-valid pipe
   always_comb begin
      oor_d     = oor_q | (acc1 & oor1) | (acc2 & oor2);
      rd1_vld_d = rd1;
      rd1_oor_d = oor1;
      rd2_vld_d = rd2;
      rd2_oor_d = oor2;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         oor_q     <= 1'b0;
         rd1_vld_q <= 1'b0;
         rd1_oor_q <= 1'b0;
         rd2_vld_q <= 1'b0;
         rd2_oor_q <= 1'b0;
      end else if (clken) begin
         oor_q     <= oor_d;
         rd1_vld_q <= rd1_vld_d;
         rd1_oor_q <= rd1_oor_d;
         rd2_vld_q <= rd2_vld_d;
         rd2_oor_q <= rd2_oor_d;
      end
   end

   assign oor_err = oor_q;

   // Out-of-range reads alias into the array, so their data is forced to zero here.
   assign rd1_dat = (rd1_vld_q & ~rd1_oor_q) ? core_q1 : '0;
   assign rd2_dat = (rd2_vld_q & ~rd2_oor_q) ? core_q2 : '0;

`ifdef SOPC_CAP_RAM_OUTREG_EN
   logic              out1_vld_q, out2_vld_q;
   logic [DATA_W-1:0] out1_dat_q, out2_dat_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out1_vld_q <= 1'b0;
         out2_vld_q <= 1'b0;
         out1_dat_q <= '0;
         out2_dat_q <= '0;
      end else if (clken) begin
         out1_vld_q <= rd1_vld_q;
         out2_vld_q <= rd2_vld_q;
         out1_dat_q <= rd1_dat;
         out2_dat_q <= rd2_dat;
      end
   end

   assign s1_readdata      = out1_dat_q;
   assign s1_readdatavalid = out1_vld_q;
   assign s2_readdata      = out2_dat_q;
   assign s2_readdatavalid = out2_vld_q;
`else
   assign s1_readdata      = rd1_dat;
   assign s1_readdatavalid = rd1_vld_q;
   assign s2_readdata      = rd2_dat;
   assign s2_readdatavalid = rd2_vld_q;
`endif

endmodule

// File: tb/tb_sopc_cap_onchip_ram_dp.sv
// Scoreboard bench for sopc_cap_onchip_ram_dp (DEPTH=16, INIT_ZERO=1).
// Stimulus pushes expected read data and arrival cycle; a negedge monitor pops and compares.
module tb_sopc_cap_onchip_ram_dp;

   localparam int DW    = 32;
   localparam int AWD   = 5;
   localparam int DEPTH = 16;
`ifdef SOPC_CAP_RAM_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            reset_n, clken;
   logic [AWD-1:0]  s1_address, s2_address;
   logic            s1_chipselect, s1_read, s1_write;
   logic            s2_chipselect, s2_read, s2_write;
   logic [3:0]      s1_byteenable, s2_byteenable;
   logic [DW-1:0]   s1_writedata, s2_writedata;
   logic [DW-1:0]   s1_readdata, s2_readdata;
   logic            s1_readdatavalid, s2_readdatavalid;
   logic            s1_waitrequest, s2_waitrequest;
   logic            oor_err, ready;

   sopc_cap_onchip_ram_dp #(
      .DATA_W (DW), .ADDR_W (AWD), .DEPTH (DEPTH), .INIT_ZERO (1)
   ) dut (
      .clk (clk), .reset_n (reset_n), .clken (clken),
      .s1_address (s1_address), .s1_chipselect (s1_chipselect), .s1_read (s1_read),
      .s1_write (s1_write), .s1_byteenable (s1_byteenable), .s1_writedata (s1_writedata),
      .s1_readdata (s1_readdata), .s1_readdatavalid (s1_readdatavalid),
      .s1_waitrequest (s1_waitrequest),
      .s2_address (s2_address), .s2_chipselect (s2_chipselect), .s2_read (s2_read),
      .s2_write (s2_write), .s2_byteenable (s2_byteenable), .s2_writedata (s2_writedata),
      .s2_readdata (s2_readdata), .s2_readdatavalid (s2_readdatavalid),
      .s2_waitrequest (s2_waitrequest),
      .oor_err (oor_err), .ready (ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   n_pass = 0;
   int   n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: every valid beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (s1_readdatavalid === 1'b1) begin
         if (q1.size() == 0) chk("s1_unexpected_rdv", 32'(s1_readdatavalid), 32'd0);
         else begin
            e = q1.pop_front();
            chk("s1_rdata", s1_readdata, e.dat);
            chk("s1_rd_cycle", cyc, e.cyc);
         end
      end
      if (s2_readdatavalid === 1'b1) begin
         if (q2.size() == 0) chk("s2_unexpected_rdv", 32'(s2_readdatavalid), 32'd0);
         else begin
            e = q2.pop_front();
            chk("s2_rdata", s2_readdata, e.dat);
            chk("s2_rd_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0;
      s1_byteenable = '0; s1_writedata = '0;
      s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0;
      s2_byteenable = '0; s2_writedata = '0;
   endtask

   // Drive one request on a port; a pure read expects data RD_LAT cycles after the request cycle.
   task automatic s_acc(input int p, input bit rd, input bit wr, input logic [AWD-1:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic [31:0] e);
      if (p == 1) begin
         s1_chipselect = 1; s1_read = rd; s1_write = wr; s1_address = a;
         s1_writedata = d; s1_byteenable = be;
         if (rd && !wr) q1.push_back('{dat: e, cyc: cyc + RD_LAT});
      end else begin
         s2_chipselect = 1; s2_read = rd; s2_write = wr; s2_address = a;
         s2_writedata = d; s2_byteenable = be;
         if (rd && !wr) q2.push_back('{dat: e, cyc: cyc + RD_LAT});
      end
   endtask

   task automatic op(input int p, input bit rd, input bit wr, input logic [AWD-1:0] a,
                     input logic [31:0] d, input logic [3:0] be, input logic [31:0] e);
      s_acc(p, rd, wr, a, d, be, e);
      tick();
      idle();
   endtask

   task automatic sweep(input string name);
      int n = 0;
      while (s1_waitrequest === 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk(name, n, 32'd17);
      chk({name, "_ready"}, 32'(ready), 32'd1);
      chk({name, "_s2_wait"}, 32'(s2_waitrequest), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; clken = 1; idle();
      repeat (3) tick();
      chk("rst_s1_rdata", s1_readdata, 32'd0);
      chk("rst_s1_rdv", 32'(s1_readdatavalid), 32'd0);
      chk("rst_s2_rdv", 32'(s2_readdatavalid), 32'd0);
      chk("rst_s1_wait", 32'(s1_waitrequest), 32'd1);
      chk("rst_s2_wait", 32'(s2_waitrequest), 32'd1);
      chk("rst_oor", 32'(oor_err), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      reset_n = 1;
      sweep("sweep_first");

      // Partial byte-lane write over known contents.
      op(1, 0, 1, 5'd3, 32'h11223344, 4'hF, 0);
      op(1, 0, 1, 5'd3, 32'hDEADBEEF, 4'h5, 0);
      op(1, 1, 0, 5'd3, 0, 4'h0, 32'h11AD33EF);

      // Simultaneous writes to one address: port 1 owns its lanes.
      s_acc(1, 0, 1, 5'd5, 32'hAAAAAAAA, 4'h3, 0);
      s_acc(2, 0, 1, 5'd5, 32'h55555555, 4'hF, 0);
      tick(); idle();
      op(1, 1, 0, 5'd5, 0, 4'h0, 32'h5555AAAA);

      // Fill 0..7 then stream them back with no gaps.
      for (int i = 0; i < 8; i++) op(2, 0, 1, 5'(i), 32'hC0DE0000 | 32'(i), 4'hF, 0);
      for (int i = 0; i < 8; i++) begin
         s_acc(2, 1, 0, 5'(i), 0, 4'h0, 32'hC0DE0000 | 32'(i));
         tick();
      end
      idle();

      // Mixed-port read-during-write returns old data.
      s_acc(1, 1, 0, 5'd2, 0, 4'h0, 32'hC0DE0002);
      s_acc(2, 0, 1, 5'd2, 32'h12345678, 4'hF, 0);
      tick(); idle();
      op(1, 1, 0, 5'd2, 0, 4'h0, 32'h12345678);

      // Read and write together: write wins, no read beat.
      op(2, 1, 1, 5'd6, 32'h0BADF00D, 4'hF, 0);
      op(2, 1, 0, 5'd6, 0, 4'h0, 32'h0BADF00D);

      // Out-of-range accesses.
      chk("oor_before", 32'(oor_err), 32'd0);
      op(1, 0, 1, 5'd16, 32'hFFFFFFFF, 4'hF, 0);
      chk("oor_after_wr", 32'(oor_err), 32'd1);
      op(1, 1, 0, 5'd0, 0, 4'h0, 32'hC0DE0000);
      op(1, 1, 0, 5'd16, 0, 4'h0, 32'h00000000);
      repeat (5) tick();
      chk("oor_sticky", 32'(oor_err), 32'd1);

      // Clock enable low: a write must not be accepted.
      clken = 0;
      s_acc(1, 0, 1, 5'd1, 32'hFFFF0000, 4'hF, 0);
      tick(); tick(); idle();
      clken = 1;
      op(1, 1, 0, 5'd1, 0, 4'h0, 32'hC0DE0001);

      // Reset mid-sweep restarts the full sweep.
      repeat (4) tick();
      reset_n = 0; tick();
      chk("oor_cleared", 32'(oor_err), 32'd0);
      reset_n = 1;
      repeat (8) tick();
      reset_n = 0; tick(); reset_n = 1;
      sweep("sweep_restart");
      for (int i = 0; i < DEPTH; i++) begin
         s_acc(1, 1, 0, 5'(i), 0, 4'h0, 32'd0);
         tick();
      end
      idle();

      // Read presented together with reset is discarded.
      repeat (4) tick();
      s1_chipselect = 1; s1_read = 1; s1_address = 5'd2;
      reset_n = 0;
      tick(); idle();
      reset_n = 1;
      sweep("sweep_inflight");

      repeat (4) tick();
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
